// File: rtl/paillier_decry_serial_if.sv
// Handshake and operand bundle for the serial Paillier decryption core.
// go is a request sampled only while idle; done/result are held until the next accepted go.
interface paillier_decry_serial_if #(
  parameter int N_WIDTH = 4096
);
  logic                   go;
  logic [2*N_WIDTH-1:0]   c;
  logic [N_WIDTH-1:0]     n;
  logic [2*N_WIDTH-1:0]   exp_n;
  logic [N_WIDTH-1:0]     lambda;
  logic [N_WIDTH-1:0]     mu;
  logic [N_WIDTH-1:0]     result;
  logic                   done;
  logic                   busy;
  logic                   err;

  modport master (
    output go, c, n, exp_n, lambda, mu,
    input  result, done, busy, err
  );

  modport slave (
    input  go, c, n, exp_n, lambda, mu,
    output result, done, busy, err
  );
endinterface

// File: rtl/paillier_decry_serial.sv
// Bit-serial Paillier decryption: L(c^lambda mod n^2) * mu mod n.
// Optional ciphertext range check enabled by defining PAILLIER_RANGE_CHECK_EN.
module paillier_decry_serial #(
  parameter int N_WIDTH = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  paillier_decry_serial_if.slave bus,
  output logic [2:0]             state_dbg
);
  localparam int W2 = 2 * N_WIDTH;
  localparam int CW = $clog2(W2);
  localparam int IW = $clog2(N_WIDTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_EXP_SQ  = 3'd2;
  localparam logic [2:0] S_EXP_MUL = 3'd3;
  localparam logic [2:0] S_LSUB    = 3'd4;
  localparam logic [2:0] S_DIV     = 3'd5;
  localparam logic [2:0] S_MMU     = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  logic [2:0]         state;
  logic [W2-1:0]      c_q, exp_n_q, acc;
  logic [N_WIDTH-1:0] n_q, lambda_q, mu_q, prod, result_q;
  logic [IW-1:0]      bit_idx;
  logic [CW-1:0]      cnt;
  logic               mm_load, done_q, busy_q;
  logic [W2-1:0]      mm_a, mm_b, mm_m;
  logic [W2+1:0]      mm_r, mm_mx, mm_t1, mm_t2, mm_t3;
  logic [N_WIDTH:0]   rem, div_sh, div_sub;
  logic               div_ge;

  // One interleaved step: r = 2r + a_msb*b, then up to two conditional subtractions of m.
  always_comb begin
    mm_mx = {2'b00, mm_m};
    mm_t1 = (mm_r << 1) + (mm_a[W2-1] ? {2'b00, mm_b} : '0);
    mm_t2 = (mm_t1 >= mm_mx) ? mm_t1 - mm_mx : mm_t1;
    mm_t3 = (mm_t2 >= mm_mx) ? mm_t2 - mm_mx : mm_t2;
  end

  // Restoring division step; acc doubles as dividend shifter and quotient collector.
  always_comb begin
    div_sh  = (rem << 1) | {{N_WIDTH{1'b0}}, acc[W2-1]};
    div_ge  = div_sh >= {1'b0, n_q};
    div_sub = div_sh - {1'b0, n_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      c_q      <= '0;
      exp_n_q  <= '0;
      acc      <= '0;
      n_q      <= '0;
      lambda_q <= '0;
      mu_q     <= '0;
      prod     <= '0;
      result_q <= '0;
      bit_idx  <= '0;
      cnt      <= '0;
      mm_load  <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
      mm_m     <= '0;
      mm_r     <= '0;
      rem      <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.go) begin
            c_q      <= bus.c;
            n_q      <= bus.n;
            exp_n_q  <= bus.exp_n;
            lambda_q <= bus.lambda;
            mu_q     <= bus.mu;
            done_q   <= 1'b0;
            result_q <= '0;
            prod     <= '0;
            busy_q   <= 1'b1;
            acc      <= W2'(1);
            bit_idx  <= IW'(N_WIDTH - 1);
            mm_load  <= 1'b1;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
`ifdef PAILLIER_RANGE_CHECK_EN
          if (c_q == '0 || c_q >= exp_n_q) begin
            prod  <= '0;
            state <= S_DONE;
          end else begin
            state <= S_EXP_SQ;
          end
`else
          state <= S_EXP_SQ;
`endif
        end
        S_EXP_SQ, S_EXP_MUL: begin
          if (mm_load) begin
            mm_a    <= acc;
            mm_b    <= (state == S_EXP_SQ) ? acc : c_q;
            mm_m    <= exp_n_q;
            mm_r    <= '0;
            cnt     <= CW'(W2 - 1);
            mm_load <= 1'b0;
          end else begin
            mm_r <= mm_t3;
            mm_a <= mm_a << 1;
            cnt  <= cnt - 1'b1;
            if (cnt == '0) begin
              acc     <= mm_t3[W2-1:0];
              mm_load <= 1'b1;
              if (state == S_EXP_SQ && lambda_q[bit_idx]) begin
                state <= S_EXP_MUL;
              end else if (bit_idx == '0) begin
                state <= S_LSUB;
              end else begin
                bit_idx <= bit_idx - 1'b1;
                state   <= S_EXP_SQ;
              end
            end
          end
        end
        S_LSUB: begin
          acc   <= acc - 1'b1;
          rem   <= '0;
          cnt   <= CW'(W2 - 1);
          state <= S_DIV;
        end
        S_DIV: begin
          rem <= div_ge ? div_sub : div_sh;
          acc <= {acc[W2-2:0], div_ge};
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            mm_load <= 1'b1;
            state   <= S_MMU;
          end
        end
        S_MMU: begin
          if (mm_load) begin
            // Narrow multiply: quotient sits in the top half so its MSB leads.
            mm_a    <= {acc[N_WIDTH-1:0], {N_WIDTH{1'b0}}};
            mm_b    <= {{N_WIDTH{1'b0}}, mu_q};
            mm_m    <= {{N_WIDTH{1'b0}}, n_q};
            mm_r    <= '0;
            cnt     <= CW'(N_WIDTH - 1);
            mm_load <= 1'b0;
          end else begin
            mm_r <= mm_t3;
            mm_a <= mm_a << 1;
            cnt  <= cnt - 1'b1;
            if (cnt == '0) begin
              prod  <= mm_t3[N_WIDTH-1:0];
              state <= S_DONE;
            end
          end
        end
        default: begin
          result_q <= prod;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PAILLIER_RANGE_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == S_IDLE && bus.go) begin
      err_q <= 1'b0;
    end else if (state == S_CHECK && (c_q == '0 || c_q >= exp_n_q)) begin
      err_q <= 1'b1;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign state_dbg  = state;
endmodule

// File: doc/paillier_decry_serial.md
# paillier_decry_serial

Parametrised, area-lean Paillier decryption engine computing result = L(c^lambda mod n^2) · mu mod n, where L(x) = (x − 1) / n. It generalises the fixed-width decryption top to any modulus width and uses bit-serial arithmetic:

- interleaved modular multiplication;
- left-to-right square-and-multiply exponentiation;
- restoring division for L().

It sits behind the key/ciphertext registers as the decryption core, using the same go/done handshake.

## Interface
- N_WIDTH, 4096, bit width of n, lambda, mu and result; n^2 operands are 2·N_WIDTH bits.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- go  in  1  start request, sampled in IDLE only.
- c  in  2·N_WIDTH  ciphertext.
- n  in  N_WIDTH  modulus, n ≥ 2.
- exp_n  in  2·N_WIDTH  n^2, precomputed by the host.
- lambda  in  N_WIDTH  private exponent.
- mu  in  N_WIDTH  λ^-1 mod n, must be < n.
- result  out  N_WIDTH  plaintext; held until the next accepted go.
- done  out  1  level; high from completion until the next accepted go.
- busy  out  1  high from go acceptance until done rises.
- err  out  1  range error flag (see Configuration).

## Operation
- Inputs are captured into internal registers when go is accepted. They may change afterwards.
- FSM states: IDLE → CHECK → EXP_SQ ⇄ EXP_MUL → LSUB → DIV → MMU → DONE → IDLE.
- IDLE:
  - On go=1: capture operands, clear done/err/result, set busy, set acc=1, set bit index to N_WIDTH−1.
  - go=0 leaves done and result unchanged.
- CHECK: one cycle; range check when enabled, else proceeds directly to EXP_SQ.
- Modmul unit (MM): interleaved, MSB-first over the multiplier bits. Operand width W: 2·N_WIDTH for mod n^2, N_WIDTH for mod n.
  - One load cycle, then W iteration cycles.
  - Each iteration: r = 2r + (a_i ? b : 0), then subtract m, then subtract m again, each only while r ≥ m.
  - Requires b < m. Internal width is W+2 bits.
  - Total W+1 cycles per multiply.
- EXP_SQ: acc = acc·acc mod n^2. Go to EXP_MUL if lambda[i]=1. Otherwise decrement i, or go to LSUB after i=0.
- EXP_MUL: acc = acc·c mod n^2, then decrement i or go to LSUB.
- All N_WIDTH lambda bits are processed, including leading zeros.
- LSUB: one cycle, x = acc − 1. acc = 0 cannot occur for valid c; it wraps to all-ones and the result is unspecified.
- DIV: restoring division of x by n, one quotient bit per cycle, 2·N_WIDTH cycles. The quotient q is truncated to N_WIDTH bits; it is exact for valid input. The remainder is discarded.
- MMU: result = q·mu mod n, N_WIDTH+1 cycles, using the same MM datapath narrowed to width N_WIDTH.
- DONE: one cycle. Drive result, set done=1, clear busy, return to IDLE.

## Timing
- Reset values: done=0, busy=0, err=0, result=0, FSM=IDLE.
- Reset mid-operation: next edge gives IDLE with all outputs zero. The aborted result is lost.
- go is accepted at edge 0. done rises at edge L:
  - L = 3 + (N_WIDTH + popcount(lambda))·(2·N_WIDTH+1) + 2·N_WIDTH + (N_WIDTH+1).
  - Example: N_WIDTH=8, lambda=90 (popcount 4) gives L = 232.
- result is valid in the same cycle done rises.
- go while busy is ignored. go held high continuously restarts the engine on the cycle after DONE; done is then high for one cycle.
- go and rst high together: rst wins.
- Latency depends on the data (popcount of lambda). The engine is not constant-time.

## Configuration
- PAILLIER_RANGE_CHECK_EN defined: CHECK tests c == 0 or c ≥ exp_n. On failure, the engine jumps to DONE:
  - err=1, result=0;
  - done rises at edge 2.
  - err is cleared on the next accepted go.
- PAILLIER_RANGE_CHECK_EN undefined:
  - err is tied to 0;
  - CHECK always passes;
  - out-of-range c gives an unspecified result, but latency still follows L.

## Test plan
- N_WIDTH=8, n=209, exp_n=43681, lambda=90, mu=72, c=8779 (= 1+42·209) → result=42, err=0, done at edge 232.
- Same key, c=1 → result=0, done at edge 232.
- Same key, lambda=0, mu=72, c=8779 → result=0, done at edge 3+8·17+16+9=164.
- Range check built in, c=43681 and then c=0 → err=1, result=0, done at edge 2. Without the macro, err stays 0 and done arrives at edge 232.
- Assert rst at edge 100 of a running decryption, then issue go with c=8779 → outputs zero after reset, then result=42. A second go pulsed while busy has no effect on result or latency.
- Back-to-back: go held high across two decryptions (c=8779, then c=1+7·209=1464) → results 42 then 7. done is high for one cycle between them and busy re-asserts immediately.
